// File: rtl/load_store_unit.sv
// Memory-stage load/store front end for a word-only DataMemory.
// Handles sub-word extraction, SB/SH read-modify-write and alignment faults.
module load_store_unit #(
  parameter int ADDR_WIDTH = 6,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic                  ReqValid,
  input  logic [2:0]            ReqOp,
  input  logic [31:0]           ReqAddr,
  input  logic [31:0]           ReqStoreData,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [31:0]           MemWriteData,
  output logic                  MemoryRead,
  output logic                  MemoryWrite,
  input  logic [31:0]           MemReadData,
  output logic                  Stall,
  output logic [31:0]           LoadData,
  output logic                  LoadValid,
  output logic                  AlignFault
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_DONE = 2'd1,
    RMW_MERGE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] load_q;

  logic        misaligned;
  logic        is_load;
  logic        is_sub_store;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_result;
  logic [31:0] merged;
  logic        unused_bits;

  assign unused_bits = ^ReqAddr[31:ADDR_WIDTH+2];

  always_comb begin
    misaligned = 1'b0;
    unique case (ReqOp)
      OP_LW, OP_SW:         misaligned = |ReqAddr[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = ReqAddr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign is_load      = (ReqOp <= OP_LBU);
  assign is_sub_store = (ReqOp == OP_SH) || (ReqOp == OP_SB);

  // Lane 0 sits in the top byte when big-endian, so the shift is mirrored.
  assign byte_sh = BIG_ENDIAN ? {~lane_q, 3'b000}
                              : {lane_q, 3'b000};
  assign half_sh = BIG_ENDIAN ? {~lane_q[1], 4'b0000}
                              : {lane_q[1], 4'b0000};

  assign rd_byte = 8'(MemReadData >> byte_sh);
  assign rd_half = 16'(MemReadData >> half_sh);

  always_comb begin
    load_result = MemReadData;
    unique case (op_q)
      OP_LH:   load_result = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_result = {16'h0000, rd_half};
      OP_LB:   load_result = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_result = {24'h000000, rd_byte};
      default: load_result = MemReadData;
    endcase
  end

  always_comb begin
    merged = MemReadData;
    if (op_q == OP_SB) begin
      merged = (MemReadData & ~(32'h0000_00ff << byte_sh))
             | (32'(ReqStoreData[7:0]) << byte_sh);
    end else begin
      merged = (MemReadData & ~(32'h0000_ffff << half_sh))
             | (32'(ReqStoreData[15:0]) << half_sh);
    end
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state  <= IDLE;
      op_q   <= OP_LW;
      lane_q <= 2'b00;
      load_q <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ReqValid && !misaligned) begin
            if (is_load) begin
              state  <= LOAD_DONE;
              op_q   <= ReqOp;
              lane_q <= ReqAddr[1:0];
            end else if (is_sub_store) begin
              state  <= RMW_MERGE;
              op_q   <= ReqOp;
              lane_q <= ReqAddr[1:0];
            end
          end
        end
        LOAD_DONE: begin
          load_q <= load_result;
          state  <= IDLE;
        end
        RMW_MERGE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, including the address.
  always_comb begin
    MemAddress   = '0;
    MemWriteData = 32'h0;
    MemoryRead   = 1'b0;
    MemoryWrite  = 1'b0;
    Stall        = 1'b0;
    LoadData     = 32'h0;
    LoadValid    = 1'b0;
    AlignFault   = 1'b0;
    if (Reset_L) begin
      MemAddress   = ReqAddr[ADDR_WIDTH+1:2];
      MemWriteData = ReqStoreData;
      LoadData     = load_q;
      unique case (state)
        IDLE: begin
          if (ReqValid) begin
            if (misaligned) begin
              AlignFault = 1'b1;
            end else if (ReqOp == OP_SW) begin
              MemoryWrite = 1'b1;
            end else begin
              MemoryRead = 1'b1;
              Stall      = 1'b1;
            end
          end
        end
        LOAD_DONE: begin
          LoadData  = load_result;
          LoadValid = 1'b1;
        end
        RMW_MERGE: begin
          MemWriteData = merged;
          MemoryWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus
// random traffic against a byte-addressed big-endian memory model.
module tb_load_store_unit;

  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LHU = 3'd2;
  localparam logic [2:0] LB  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] SW  = 3'd5;
  localparam logic [2:0] SH  = 3'd6;
  localparam logic [2:0] SB  = 3'd7;

  logic        Clock = 1'b0;
  logic        Reset_L = 1'b1;
  logic        ReqValid = 1'b0;
  logic [2:0]  ReqOp = 3'd0;
  logic [31:0] ReqAddr = 32'h0;
  logic [31:0] ReqStoreData = 32'h0;
  logic [5:0]  MemAddress;
  logic [31:0] MemWriteData;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [31:0] MemReadData = 32'h0;
  logic        Stall;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        AlignFault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  logic [7:0]  ref_bytes [256];

  load_store_unit dut (
    .Clock(Clock), .Reset_L(Reset_L), .ReqValid(ReqValid),
    .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqStoreData(ReqStoreData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
    .MemReadData(MemReadData), .Stall(Stall), .LoadData(LoadData),
    .LoadValid(LoadValid), .AlignFault(AlignFault)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) if (MemoryRead) MemReadData <= mem[MemAddress];
  always @(negedge Clock) if (MemoryWrite) mem[MemAddress] <= MemWriteData;

  function automatic logic ref_misaligned(input logic [2:0] op, input logic [31:0] a);
    if (op == LW || op == SW) return a[1:0] != 2'b00;
    if (op == LH || op == LHU || op == SH) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [5:0] w);
    logic [7:0] i;
    i = {w, 2'b00};
    return {ref_bytes[i], ref_bytes[i+8'd1], ref_bytes[i+8'd2], ref_bytes[i+8'd3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [7:0] i, j, b0, b1;
    i = a[7:0];
    j = i + 8'd1;
    b0 = ref_bytes[i];
    b1 = ref_bytes[j];
    case (op)
      LW:      return ref_word(a[7:2]);
      LH:      return {{16{b0[7]}}, b0, b1};
      LHU:     return {16'h0, b0, b1};
      LB:      return {{24{b0[7]}}, b0};
      default: return {24'h0, b0};
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] i;
    i = a[7:0];
    if (op == SW) begin
      ref_bytes[i] = d[31:24]; ref_bytes[i+8'd1] = d[23:16];
      ref_bytes[i+8'd2] = d[15:8]; ref_bytes[i+8'd3] = d[7:0];
    end else if (op == SH) begin
      ref_bytes[i] = d[15:8]; ref_bytes[i+8'd1] = d[7:0];
    end else if (op == SB) begin
      ref_bytes[i] = d[7:0];
    end
  endtask

  // Drives one request starting at posedge+1 and follows it until Stall drops.
  task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                         output int cyc, output logic [3:0] spat, output int nrd,
                         output int nwr, output int nflt, output int nlv,
                         output logic [31:0] ld, output logic [5:0] maddr);
    logic st;
    ReqValid = 1'b1; ReqOp = op; ReqAddr = a; ReqStoreData = d;
    cyc = 0; spat = 4'b0; nrd = 0; nwr = 0; nflt = 0; nlv = 0;
    ld = 32'hx; maddr = 6'h0;
    do begin
      #2;
      spat[cyc[1:0]] = Stall;
      nrd += int'(MemoryRead); nwr += int'(MemoryWrite);
      nflt += int'(AlignFault); nlv += int'(LoadValid);
      if (LoadValid) ld = LoadData;
      if (cyc == 0) maddr = MemAddress;
      st = Stall;
      cyc++;
      @(posedge Clock); #1;
    end while (st && cyc < 4);
  endtask

  task automatic go_idle();
    ReqValid = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    Reset_L = 1'b0;
    ReqValid = 1'b1; ReqOp = SW; ReqAddr = 32'h10; ReqStoreData = 32'h12345678;
    #12;
    checks++; if (MemoryWrite !== 1'b0) begin errors++; $display("FAIL rst_wr got %b want 0", MemoryWrite); end
    checks++; if (MemoryRead !== 1'b0) begin errors++; $display("FAIL rst_rd got %b want 0", MemoryRead); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", Stall); end
    checks++; if (LoadValid !== 1'b0 || AlignFault !== 1'b0) begin errors++; $display("FAIL rst_flags got lv=%b af=%b want 0", LoadValid, AlignFault); end
    checks++; if (LoadData !== 32'h0) begin errors++; $display("FAIL rst_ld got %h want 0", LoadData); end
    checks++; if (MemAddress !== 6'h0 || MemWriteData !== 32'h0) begin errors++; $display("FAIL rst_bus got a=%h d=%h want 0", MemAddress, MemWriteData); end
    ReqOp = LW;
    @(posedge Clock); #1;
    Reset_L = 1'b1;
    ReqValid = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic seed_memory();
    int cyc, nrd, nwr, nflt, nlv, bad;
    logic [3:0] sp; logic [31:0] ld; logic [5:0] ma;
    bad = 0;
    for (int w = 0; w < 64; w++) begin
      run_req(SW, 32'(w * 4), 32'h0, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
      ref_store(SW, 32'(w * 4), 32'h0);
      if (nwr != 1 || cyc != 1 || ma != 6'(w)) bad++;
    end
    go_idle();
    checks++; if (bad != 0) begin errors++; $display("FAIL seed_sw got %0d bad writes want 0", bad); end
  endtask

  task automatic test_sw_lw();
    int cyc, nrd, nwr, nflt, nlv;
    logic [3:0] sp; logic [31:0] ld; logic [5:0] ma;
    run_req(SW, 32'h10, 32'hDEADBEEF, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
    ref_store(SW, 32'h10, 32'hDEADBEEF);
    checks++; if (nwr != 1 || cyc != 1 || nrd != 0) begin errors++; $display("FAIL sw_strobe got wr=%0d cyc=%0d rd=%0d want 1,1,0", nwr, cyc, nrd); end
    checks++; if (ma !== 6'd4) begin errors++; $display("FAIL sw_addr got %0d want 4", ma); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got %h want deadbeef", mem[4]); end
    run_req(LW, 32'h10, 32'h0, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
    checks++; if (cyc != 2 || sp !== 4'b0001) begin errors++; $display("FAIL lw_stall got cyc=%0d pat=%b want 2,0001", cyc, sp); end
    checks++; if (nlv != 1 || ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got lv=%0d %h want 1 deadbeef", nlv, ld); end
    go_idle();
  endtask

  task automatic test_subword_loads();
    int cyc, nrd, nwr, nflt, nlv;
    logic [3:0] sp; logic [31:0] ld; logic [5:0] ma;
    logic [2:0]  ops [6];
    logic [31:0] ads [6];
    logic [31:0] exp [6];
    ops = '{LB, LBU, LH, LHU, LB, LBU};
    ads = '{32'h10, 32'h11, 32'h12, 32'h10, 32'h13, 32'h112};
    exp = '{32'hFFFFFF80, 32'h00000081, 32'hFFFFC2C3, 32'h00008081, 32'hFFFFFFC3, 32'h000000C2};
    run_req(SW, 32'h10, 32'h8081C2C3, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
    ref_store(SW, 32'h10, 32'h8081C2C3);
    for (int k = 0; k < 6; k++) begin
      run_req(ops[k], ads[k], 32'h0, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
      checks++; if (ld !== exp[k] || nlv != 1 || cyc != 2) begin errors++; $display("FAIL subload_%0d got %h lv=%0d cyc=%0d want %h", k, ld, nlv, cyc, exp[k]); end
    end
    go_idle();
  endtask

  task automatic test_rmw();
    int cyc, nrd, nwr, nflt, nlv;
    logic [3:0] sp; logic [31:0] ld; logic [5:0] ma;
    run_req(SW, 32'h10, 32'h11223344, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
    ref_store(SW, 32'h10, 32'h11223344);
    run_req(SB, 32'h12, 32'hDEADBEAA, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
    ref_store(SB, 32'h12, 32'hDEADBEAA);
    checks++; if (cyc != 2 || sp !== 4'b0001 || nrd != 1 || nwr != 1) begin errors++; $display("FAIL sb_timing got cyc=%0d pat=%b rd=%0d wr=%0d want 2,0001,1,1", cyc, sp, nrd, nwr); end
    checks++; if (mem[4] !== 32'h1122AA44) begin errors++; $display("FAIL sb_mem got %h want 1122aa44", mem[4]); end
    run_req(SH, 32'h10, 32'h12345566, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
    ref_store(SH, 32'h10, 32'h12345566);
    checks++; if (cyc != 2 || sp !== 4'b0001 || nwr != 1) begin errors++; $display("FAIL sh_timing got cyc=%0d pat=%b wr=%0d want 2,0001,1", cyc, sp, nwr); end
    checks++; if (mem[4] !== 32'h5566AA44) begin errors++; $display("FAIL sh_mem got %h want 5566aa44", mem[4]); end
    go_idle();
  endtask

  task automatic test_misaligned();
    int cyc, nrd, nwr, nflt, nlv;
    logic [3:0] sp; logic [31:0] ld; logic [5:0] ma;
    logic [2:0]  ops [3];
    logic [31:0] ads [3];
    ops = '{LW, SH, SW};
    ads = '{32'h13, 32'h11, 32'h12};
    for (int k = 0; k < 3; k++) begin
      run_req(ops[k], ads[k], 32'hFFFFFFFF, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
      checks++; if (nflt != 1 || nrd != 0 || nwr != 0 || cyc != 1) begin errors++; $display("FAIL misalign_%0d got af=%0d rd=%0d wr=%0d cyc=%0d want 1,0,0,1", k, nflt, nrd, nwr, cyc); end
    end
    go_idle();
    checks++; if (mem[4] !== 32'h5566AA44) begin errors++; $display("FAIL misalign_mem got %h want 5566aa44", mem[4]); end
  endtask

  task automatic test_reset_rmw();
    int cyc, nrd, nwr, nflt, nlv;
    logic [3:0] sp; logic [31:0] ld; logic [5:0] ma;
    ReqValid = 1'b1; ReqOp = SB; ReqAddr = 32'h0; ReqStoreData = 32'hFF;
    #2;
    checks++; if (Stall !== 1'b1 || MemoryRead !== 1'b1) begin errors++; $display("FAIL rrmw_start got st=%b rd=%b want 1,1", Stall, MemoryRead); end
    @(posedge Clock); #1;
    Reset_L = 1'b0;
    #2;
    checks++; if (MemoryWrite !== 1'b0 || Stall !== 1'b0 || LoadValid !== 1'b0 || MemWriteData !== 32'h0 || LoadData !== 32'h0) begin
      errors++; $display("FAIL rrmw_outs got wr=%b st=%b lv=%b wd=%h ld=%h want 0", MemoryWrite, Stall, LoadValid, MemWriteData, LoadData); end
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    Reset_L = 1'b1;
    #2;
    checks++; if (MemoryWrite !== 1'b0 || MemoryRead !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL rrmw_idle got wr=%b rd=%b st=%b want 0", MemoryWrite, MemoryRead, Stall); end
    checks++; if (mem[0] !== 32'h0) begin errors++; $display("FAIL rrmw_mem got %h want 0", mem[0]); end
    @(posedge Clock); #1;
    run_req(LW, 32'h0, 32'h0, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
    checks++; if (cyc != 2 || ld !== ref_load(LW, 32'h0)) begin errors++; $display("FAIL rrmw_lw got cyc=%0d %h want 2 %h", cyc, ld, ref_load(LW, 32'h0)); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int c1, c2, c3, nrd, nwr, nflt, nlv;
    logic [3:0] s1, s2, s3; logic [31:0] l1, l3; logic [5:0] ma;
    logic [31:0] e1, e3;
    e1 = ref_load(LB, 32'h0);
    run_req(LB, 32'h0, 32'h0, c1, s1, nrd, nwr, nflt, nlv, l1, ma);
    run_req(SB, 32'h1, 32'h000000A5, c2, s2, nrd, nwr, nflt, nlv, l3, ma);
    ref_store(SB, 32'h1, 32'h000000A5);
    e3 = ref_load(LW, 32'h0);
    run_req(LW, 32'h0, 32'h0, c3, s3, nrd, nwr, nflt, nlv, l3, ma);
    go_idle();
    checks++; if ({s3[1:0], s2[1:0], s1[1:0]} !== 6'b010101 || c1 + c2 + c3 != 6) begin
      errors++; $display("FAIL b2b_stall got %b%b%b cyc=%0d want 010101 6", s3[1:0], s2[1:0], s1[1:0], c1 + c2 + c3); end
    checks++; if (l1 !== e1) begin errors++; $display("FAIL b2b_lb got %h want %h", l1, e1); end
    checks++; if (l3 !== e3 || e3 !== 32'h00A50000) begin errors++; $display("FAIL b2b_lw got %h model %h want 00a50000", l3, e3); end
  endtask

  task automatic test_random();
    int cyc, nrd, nwr, nflt, nlv;
    logic [3:0] sp; logic [31:0] ld; logic [5:0] ma;
    logic [2:0] op; logic [31:0] a, d, e;
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == LW || op == SW) a[1:0] = 2'b00;
        else if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
      end
      e = ref_load(op, a);
      run_req(op, a, d, cyc, sp, nrd, nwr, nflt, nlv, ld, ma);
      checks++; if (ma !== a[7:2]) begin errors++; $display("FAIL rnd_addr_%0d got %h want %h", n, ma, a[7:2]); end
      if (ref_misaligned(op, a)) begin
        checks++; if (nflt != 1 || nrd != 0 || nwr != 0 || cyc != 1) begin errors++; $display("FAIL rnd_fault_%0d got af=%0d rd=%0d wr=%0d cyc=%0d want 1,0,0,1", n, nflt, nrd, nwr, cyc); end
      end else if (op <= LBU) begin
        checks++; if (ld !== e || nlv != 1 || cyc != 2 || nwr != 0) begin errors++; $display("FAIL rnd_load_%0d op=%0d a=%h got %h cyc=%0d want %h", n, op, a, ld, cyc, e); end
      end else begin
        ref_store(op, a, d);
        checks++; if (nwr != 1 || nlv != 0 || cyc != ((op == SW) ? 1 : 2) || nflt != 0) begin errors++; $display("FAIL rnd_store_%0d op=%0d got wr=%0d cyc=%0d", n, op, nwr, cyc); end
        if ($urandom_range(0, 1) == 0) go_idle();
        checks++; if (mem[a[7:2]] !== ref_word(a[7:2])) begin errors++; $display("FAIL rnd_mem_%0d got %h want %h", n, mem[a[7:2]], ref_word(a[7:2])); end
      end
      if ($urandom_range(0, 4) == 0) go_idle();
    end
    go_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h0;
    #1;
    test_reset();
    seed_memory();
    test_sw_lw();
    test_subword_loads();
    test_rmw();
    test_misaligned();
    test_reset_rmw();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
